interval_meter: RTL and testbench
=================================

Name: interval_meter

Overview:
- Measures the number of clock cycles between a `start` pulse and a later `stop` pulse.
- Presents the result on a valid/ready output with a saturation flag.
- It is the measuring counterpart of the team's one-shot countdown timer: a timer loaded with N that starts when the meter starts drives `stop` N cycles later, and the meter must report exactly N.
- Used for latency checks, pulse-width capture and self-test of timer instances.

Parameters:
- WIDTH, 8, width of the measurement counter and result; supported range is WIDTH >= 2.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start  input  1  begin (or restart) a measurement; sampled every cycle.
- stop  input  1  end the current measurement; sampled every cycle.
- busy  output  1  high while a measurement is in progress (RUNNING).
- result  output  WIDTH  measured cycle count; stable while valid is high.
- valid  output  1  result available.
- ready  input  1  consumer accepts result when valid && ready.
- overflow  output  1  qualifies result: the interval exceeded 2^WIDTH-1 cycles; only meaningful while valid.

Behaviour:
- Clock and reset: single clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, valid=0, result=0, overflow=0, internal counter=0.
- Reset mid-operation discards any measurement or pending result; `rst_i` has priority over all inputs.
- States: IDLE, RUNNING, RESULT.
- IDLE:
  - `start` -> RUNNING.
  - `stop` alone is ignored.
  - `start` && `stop` in the same cycle -> RUNNING; `stop` is ignored.
- RUNNING:
  - The counter advances one per cycle.
  - Definition: `start` sampled at edge E0, `stop` sampled at edge EN (N >= 1) => result = N.
  - On `stop` -> RESULT; valid rises in the cycle after EN.
  - `start` (with or without `stop`) restarts: the count origin moves to this edge, no result is produced, state stays RUNNING. `start` wins, matching timer reload priority.
- RESULT:
  - valid=1; result and overflow are held until the handshake.
  - valid && ready -> IDLE, valid falls the next cycle.
  - `start` in the same cycle as the handshake -> RUNNING directly, origin at that edge, no lost cycle.
  - `start` without the handshake is ignored.
  - `stop` is ignored.
- Saturation:
  - The counter saturates at 2^WIDTH-1 and never wraps.
  - If N > 2^WIDTH-1: result = 2^WIDTH-1 and overflow=1.
  - An exact N = 2^WIDTH-1 gives overflow=0.
- busy = (state == RUNNING), registered; no combinational path from any input to any output.

Optional Feature:
- Macro: INTERVAL_METER_TIMEOUT_EN.
- With the macro defined:
  - Adds input `timeout` [WIDTH-1:0] and output `timed_out` (1 bit, reset 0).
  - If RUNNING and the count reaches `timeout` (nonzero) without `stop`, the block goes to RESULT with result = `timeout`, overflow=0, timed_out=1.
  - `timed_out` is held and cleared with valid.
  - `timeout` = 0 disables the check.
  - A `stop` on the same edge as the timeout is a normal stop; timed_out=0.
- Without the macro: the ports are absent and a measurement runs until `stop` or saturation indefinitely.

Decomposition:
- Shared package `interval_meter_pkg` holds:
  - the state encoding localparams (IDLE/RUNNING/RESULT);
  - a `SAT_MAX(width)` constant function.
- One natural sub-module, `sat_counter`, with WIDTH, clear, enable, count and saturated outputs; it is reusable by other timing blocks.
- The FSM and output register stay in `interval_meter`.

Test Plan:
- Basic: WIDTH=8, `start` at cycle 10, `stop` at cycle 35 -> valid at cycle 36, result=25, overflow=0; ready=1 -> valid low at 37.
- Timer loopback: timer loaded with 7 and meter started on the same edge, timer completion drives `stop` -> result=7; repeat for 1 and 255 -> results 1 and 255 with overflow=0.
- Saturation: WIDTH=4, `stop` 20 cycles after `start` -> result=15, overflow=1; `stop` at exactly 15 -> result=15, overflow=0.
- Backpressure and priorities:
  - ready=0 for 5 cycles while `start`/`stop` toggle -> result unchanged, no new measurement.
  - `start` with the handshake -> busy the next cycle, next result counted from that edge.
  - `start` during RUNNING at +4, `stop` at +9 -> result=5.
- Reset: `rst_i` asserted mid-RUNNING and during RESULT -> next cycle busy=0, valid=0, result=0; `start`+`stop` together in IDLE -> RUNNING with no result.
- Timeout (INTERVAL_METER_TIMEOUT_EN): timeout=12, no `stop` -> result=12, timed_out=1; `stop` on the same edge -> timed_out=0.

Source files
------------

// File: rtl/interval_meter_pkg.sv
// Shared definitions for interval_meter and its reusable saturating counter:
// state encoding and the saturation ceiling helper.
package interval_meter_pkg;

   localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
   localparam logic [1:0] ST_RUNNING_ENC = 2'd1;
   localparam logic [1:0] ST_RESULT_ENC  = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE_ENC,
      RUNNING = ST_RUNNING_ENC,
      RESULT  = ST_RESULT_ENC
   } state_e;

   // Largest value representable in a counter of the given width.
   function automatic longint unsigned SAT_MAX(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones ceiling instead of wrapping.
// clear_i has priority over enable_i and restarts the count at zero.
module sat_counter
   import interval_meter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [WIDTH-1:0] count_o,
   output logic             saturated_o
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(SAT_MAX(WIDTH));
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // NOTE: next-state starts from a hold default so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != MAX)) begin
         count_d = count_q + ONE;
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o     = count_q;
   assign saturated_o = (count_q == MAX);

endmodule

// File: rtl/interval_meter.sv
// Measures cycles between a start and a later stop pulse; result on valid/ready.
// Optional hard timeout enabled by defining INTERVAL_METER_TIMEOUT_EN.
module interval_meter
   import interval_meter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             valid,
   input  logic             ready,
   output logic             overflow
`ifdef INTERVAL_METER_TIMEOUT_EN
   ,
   input  logic [WIDTH-1:0] timeout,
   output logic             timed_out
`endif
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(SAT_MAX(WIDTH));
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q;
   logic             busy_q;
   logic             valid_q;
   logic             overflow_q;
   logic [WIDTH-1:0] result_q;

   logic [WIDTH-1:0] count;
   logic             saturated;
   logic             handshake;
   logic             restart;
   logic             running;
   logic [WIDTH-1:0] meas;

   // Counter holds N-1 at the stop edge, so the measurement is count+1;
   // a saturated counter means N exceeded the ceiling.
   always_comb begin
      handshake = (state_q == RESULT) && ready;
      restart   = start && ((state_q != RESULT) || handshake);
      running   = (state_q == RUNNING);
      meas      = saturated ? MAX : (count + ONE);
   end

   sat_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (restart),
      .enable_i   (running),
      .count_o    (count),
      .saturated_o(saturated)
   );

`ifdef INTERVAL_METER_TIMEOUT_EN
   logic timed_out_q;
   logic timeout_hit;

   assign timeout_hit = (timeout != '0) && (count == (timeout - ONE));
`endif

   // NOTE: synchronous reset returns every control and output register to its idle value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
`ifdef INTERVAL_METER_TIMEOUT_EN
         timed_out_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUNNING;
                  busy_q  <= 1'b1;
               end
            end
            RUNNING: begin
               if (!start && stop) begin
                  state_q    <= RESULT;
                  busy_q     <= 1'b0;
                  valid_q    <= 1'b1;
                  result_q   <= meas;
                  overflow_q <= saturated;
`ifdef INTERVAL_METER_TIMEOUT_EN
                  timed_out_q <= 1'b0;
               end else if (!start && timeout_hit) begin
                  state_q     <= RESULT;
                  busy_q      <= 1'b0;
                  valid_q     <= 1'b1;
                  result_q    <= timeout;
                  overflow_q  <= 1'b0;
                  timed_out_q <= 1'b1;
`endif
               end
            end
            RESULT: begin
               if (ready) begin
                  valid_q <= 1'b0;
`ifdef INTERVAL_METER_TIMEOUT_EN
                  timed_out_q <= 1'b0;
`endif
                  if (start) begin
                     state_q <= RUNNING;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign result   = result_q;
   assign overflow = overflow_q;
`ifdef INTERVAL_METER_TIMEOUT_EN
   assign timed_out = timed_out_q;
`endif

endmodule

// File: tb/tb_interval_meter.sv
// Self-checking bench: 8-bit and 4-bit meters share stimulus and are compared
// each cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_interval_meter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       ready;

   logic       busy8, valid8, ovf8;
   logic [7:0] res8;
   logic       busy4, valid4, ovf4;
   logic [3:0] res4;
`ifdef INTERVAL_METER_TIMEOUT_EN
   logic [7:0] tmo8;
   logic [3:0] tmo4;
   logic       to8, to4;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: remembers the edge number of the origin and derives
   // the measurement as a plain difference of edge numbers.
   typedef enum {M_IDLE, M_RUN, M_RES} mstate_e;
   mstate_e m_st[2];
   int      m_org[2];
   int      m_res[2];
   logic    m_ovf[2];
   logic    m_to[2];
   int      m_max[2] = '{255, 15};
   int      m_tmo = 0;

   always #5 clk = ~clk;

   interval_meter #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .start(start), .stop(stop),
      .busy(busy8), .result(res8), .valid(valid8), .ready(ready),
      .overflow(ovf8)
`ifdef INTERVAL_METER_TIMEOUT_EN
      , .timeout(tmo8), .timed_out(to8)
`endif
   );

   interval_meter #(.WIDTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start(start), .stop(stop),
      .busy(busy4), .result(res4), .valid(valid4), .ready(ready),
      .overflow(ovf4)
`ifdef INTERVAL_METER_TIMEOUT_EN
      , .timeout(tmo4), .timed_out(to4)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge();
      int n;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_st[i]  = M_IDLE;
            m_res[i] = 0;
            m_ovf[i] = 1'b0;
            m_to[i]  = 1'b0;
         end else begin
            case (m_st[i])
               M_IDLE: if (start) begin
                  m_st[i]  = M_RUN;
                  m_org[i] = cyc;
               end
               M_RUN: begin
                  n = cyc - m_org[i];
                  if (start) begin
                     m_org[i] = cyc;
                  end else if (stop) begin
                     m_res[i] = (n > m_max[i]) ? m_max[i] : n;
                     m_ovf[i] = (n > m_max[i]);
                     m_to[i]  = 1'b0;
                     m_st[i]  = M_RES;
                  end else if (m_tmo != 0 && n == m_tmo) begin
                     m_res[i] = m_tmo;
                     m_ovf[i] = 1'b0;
                     m_to[i]  = 1'b1;
                     m_st[i]  = M_RES;
                  end
               end
               default: if (ready) begin
                  m_to[i] = 1'b0;
                  if (start) begin
                     m_st[i]  = M_RUN;
                     m_org[i] = cyc;
                  end else begin
                     m_st[i] = M_IDLE;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic check_all();
      check("busy8", busy8, m_st[0] == M_RUN);
      check("valid8", valid8, m_st[0] == M_RES);
      if (m_st[0] == M_RES) begin
         check("result8", res8, m_res[0]);
         check("overflow8", ovf8, m_ovf[0]);
      end
      check("busy4", busy4, m_st[1] == M_RUN);
      check("valid4", valid4, m_st[1] == M_RES);
      if (m_st[1] == M_RES) begin
         check("result4", res4, m_res[1]);
         check("overflow4", ovf4, m_ovf[1]);
      end
`ifdef INTERVAL_METER_TIMEOUT_EN
      check("timed_out8", to8, m_to[0]);
      check("timed_out4", to4, m_to[1]);
`endif
   endtask

   task automatic step(input logic s, input logic p, input logic r, input logic rs = 1'b0);
      start = s;
      stop  = p;
      ready = r;
      rst   = rs;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // A one-shot timer loaded with n on the start edge drives stop n edges later.
   task automatic run_interval(input int n, input logic r);
      step(1'b1, 1'b0, r);
      repeat (n - 1) step(1'b0, 1'b0, r);
      step(1'b0, 1'b1, r);
   endtask

   initial begin
      start = 1'b0; stop = 1'b0; ready = 1'b0; rst = 1'b1;
`ifdef INTERVAL_METER_TIMEOUT_EN
      tmo8 = '0; tmo4 = '0;
`endif
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_result8", res8, 32'd0);
      check("reset_result4", res4, 32'd0);
      check("reset_overflow8", ovf8, 32'd0);

      // Basic: start, stop 25 edges later, consumer ready throughout.
      repeat (6) step(1'b0, 1'b0, 1'b1);
      run_interval(25, 1'b1);
      check("basic_valid", valid8, 32'd1);
      check("basic_result", res8, 32'd25);
      step(1'b0, 1'b0, 1'b1);
      check("basic_valid_low", valid8, 32'd0);

      // Timer loopback and 4-bit saturation boundaries.
      run_interval(7, 1'b1);   step(1'b0, 1'b0, 1'b1);
      run_interval(1, 1'b1);   step(1'b0, 1'b0, 1'b1);
      run_interval(255, 1'b1);
      check("loop255_result", res8, 32'd255);
      check("loop255_overflow", ovf8, 32'd0);
      step(1'b0, 1'b0, 1'b1);
      run_interval(20, 1'b1);
      check("sat20_result4", res4, 32'd15);
      check("sat20_overflow4", ovf4, 32'd1);
      step(1'b0, 1'b0, 1'b1);
      run_interval(15, 1'b1);
      check("exact15_overflow4", ovf4, 32'd0);
      step(1'b0, 1'b0, 1'b1);
      run_interval(16, 1'b1);  step(1'b0, 1'b0, 1'b1);
      run_interval(256, 1'b1);
      check("sat256_overflow8", ovf8, 32'd1);
      step(1'b0, 1'b0, 1'b1);

      // Backpressure: result held while start/stop toggle, then start with handshake.
      run_interval(10, 1'b0);
      for (int k = 0; k < 5; k++) step(k[0], ~k[0], 1'b0);
      check("bp_result", res8, 32'd10);
      step(1'b1, 1'b0, 1'b1);
      check("hs_start_busy", busy8, 32'd1);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);

      // Restart during RUNNING at +4, stop at +9.
      step(1'b1, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      check("restart_result", res8, 32'd5);
      step(1'b0, 1'b0, 1'b1);

      // Reset mid-RUNNING and during RESULT.
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_run_busy", busy8, 32'd0);
      run_interval(6, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_res_valid", valid8, 32'd0);
      check("rst_res_result", res8, 32'd0);

      // start and stop together in IDLE: runs, no result.
      step(1'b1, 1'b1, 1'b1);
      check("idle_both_busy", busy8, 32'd1);
      repeat (2) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);

`ifdef INTERVAL_METER_TIMEOUT_EN
      tmo8 = 8'd12; tmo4 = 4'd12; m_tmo = 12;
      step(1'b1, 1'b0, 1'b0);
      repeat (14) step(1'b0, 1'b0, 1'b0);
      check("timeout_result", res8, 32'd12);
      check("timeout_flag", to8, 32'd1);
      step(1'b0, 1'b0, 1'b1);
      run_interval(12, 1'b0);
      check("timeout_stop_flag", to8, 32'd0);
      step(1'b0, 1'b0, 1'b1);
`endif

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         step($urandom_range(15) == 0, $urandom_range(7) == 0,
              $urandom_range(1) == 1, $urandom_range(199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
